// File: rtl/seq_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_gen : serial test-sequence generator, MSB-first, DIV clocks per bit
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module seq_gen #(
   parameter int PAT_W = 16,
   parameter int LEN_W = 5,
   parameter int DIV   = 4
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             loop,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   output logic             data_out,
   output logic             bit_stb,
   output logic             busy,
   output logic             frame_done,
   output logic [7:0]       frame_cnt
);

   localparam int IDX_W = $clog2(PAT_W);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [LEN_W:0]   LEN_MAX  = (LEN_W+1)'(PAT_W);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0]       state;
   logic [PAT_W-1:0] shadow;
   logic [IDX_W-1:0] first_idx;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] div_cnt;

   logic             len_ok;
   logic [IDX_W-1:0] len_idx;
   logic             bit_last;
   logic             frame_end;

   assign len_ok    = (len != '0) && ({1'b0, len} <= LEN_MAX);
   assign len_idx   = IDX_W'(len - 1'b1);
   assign bit_last  = (div_cnt == CNT_LAST);
   assign frame_end = bit_last && (idx == '0);
   assign busy      = (state == S_SEND);

   // Each branch loads data_out with the bit that will be on the line next
   // cycle, so the serial output comes straight from a flop.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         shadow     <= '0;
         first_idx  <= '0;
         idx        <= '0;
         div_cnt    <= '0;
         data_out   <= 1'b0;
         bit_stb    <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !stop && len_ok) begin
                  state     <= S_SEND;
                  shadow    <= pattern;
                  first_idx <= len_idx;
                  idx       <= len_idx;
                  div_cnt   <= '0;
                  data_out  <= pattern[len_idx];
                  bit_stb   <= 1'b1;
               end else begin
                  data_out <= 1'b0;
                  bit_stb  <= 1'b0;
               end
            end
            S_SEND: begin
               if (frame_end) begin
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 1'b1;
                  if (loop && !stop) begin
                     idx      <= first_idx;
                     div_cnt  <= '0;
                     data_out <= shadow[first_idx];
                     bit_stb  <= 1'b1;
                  end else begin
                     state    <= S_IDLE;
                     data_out <= 1'b0;
                     bit_stb  <= 1'b0;
                  end
               end else if (stop) begin
                  state    <= S_IDLE;
                  data_out <= 1'b0;
                  bit_stb  <= 1'b0;
               end else if (bit_last) begin
                  idx      <= idx - 1'b1;
                  div_cnt  <= '0;
                  data_out <= shadow[idx - 1'b1];
                  bit_stb  <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
                  bit_stb <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               data_out <= 1'b0;
               bit_stb  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_gen : directed + randomized bench for seq_gen (DIV=4 and DIV=1)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_seq_gen;

   logic        sysclk = 1'b0;
   logic        rst    = 1'b0;
   logic        start  = 1'b0;
   logic        stop   = 1'b0;
   logic        loop   = 1'b0;
   logic [15:0] pattern = '0;
   logic [4:0]  len    = '0;

   logic       data4, stb4, busy4, done4;
   logic [7:0] cnt4;
   logic       data1, stb1, busy1, done1;
   logic [7:0] cnt1;

   int n_total = 0;
   int n_pass  = 0;

   always #5 sysclk = ~sysclk;

   seq_gen #(.PAT_W(16), .LEN_W(5), .DIV(4)) u_dut4 (
      .sysclk(sysclk), .rst(rst), .start(start), .stop(stop), .loop(loop),
      .pattern(pattern), .len(len),
      .data_out(data4), .bit_stb(stb4), .busy(busy4),
      .frame_done(done4), .frame_cnt(cnt4)
   );

   seq_gen #(.PAT_W(16), .LEN_W(5), .DIV(1)) u_dut1 (
      .sysclk(sysclk), .rst(rst), .start(start), .stop(stop), .loop(loop),
      .pattern(pattern), .len(len),
      .data_out(data1), .bit_stb(stb1), .busy(busy1),
      .frame_done(done1), .frame_cnt(cnt1)
   );

   // Reference: a frame is a timeline t = 0 .. len*div-1; the bit on the
   // line is pat[len-1 - t/div] and a strobe marks t being a multiple of div.
   typedef struct {
      bit          busy;
      int          t;
      logic [15:0] pat;
      int          len;
      bit          done;
      int          cnt;
   } model_t;

   model_t m4, m1;

   function automatic model_t m_reset();
      model_t s;
      s.busy = 1'b0; s.t = 0; s.pat = '0; s.len = 0; s.done = 1'b0; s.cnt = 0;
      return s;
   endfunction

   function automatic model_t m_step(model_t s, int div);
      model_t n = s;
      n.done = 1'b0;
      if (!s.busy) begin
         if (start && !stop && int'(len) >= 1 && int'(len) <= 16) begin
            n.busy = 1'b1;
            n.pat  = pattern;
            n.len  = int'(len);
            n.t    = 0;
         end
      end else if (s.t + 1 == s.len * div) begin
         n.done = 1'b1;
         n.cnt  = (s.cnt + 1) % 256;
         if (loop && !stop) n.t = 0;
         else               n.busy = 1'b0;
      end else if (stop) begin
         n.busy = 1'b0;
      end else begin
         n.t = s.t + 1;
      end
      return n;
   endfunction

   function automatic logic m_data(model_t s, int div);
      if (!s.busy) return 1'b0;
      return s.pat[s.len - 1 - s.t / div];
   endfunction

   function automatic logic m_stb(model_t s, int div);
      return s.busy && (s.t % div == 0);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic compare_all();
      check("d4.data",  {31'd0, data4}, {31'd0, m_data(m4, 4)});
      check("d4.stb",   {31'd0, stb4},  {31'd0, m_stb(m4, 4)});
      check("d4.busy",  {31'd0, busy4}, {31'd0, m4.busy});
      check("d4.done",  {31'd0, done4}, {31'd0, m4.done});
      check("d4.cnt",   {24'd0, cnt4},  32'(m4.cnt));
      check("d1.data",  {31'd0, data1}, {31'd0, m_data(m1, 1)});
      check("d1.stb",   {31'd0, stb1},  {31'd0, m_stb(m1, 1)});
      check("d1.busy",  {31'd0, busy1}, {31'd0, m1.busy});
      check("d1.done",  {31'd0, done1}, {31'd0, m1.done});
      check("d1.cnt",   {24'd0, cnt1},  32'(m1.cnt));
   endtask

   task automatic cycle();
      @(posedge sysclk);
      if (rst) begin
         m4 = m_reset();
         m1 = m_reset();
      end else begin
         m4 = m_step(m4, 4);
         m1 = m_step(m1, 1);
      end
      #1;
      compare_all();
   endtask

   initial begin
      m4 = m_reset();
      m1 = m_reset();

      // reset state
      #2 rst = 1'b1;
      #1 compare_all();
      repeat (2) cycle();
      rst = 1'b0;
      cycle();

      // single frame: 0x001B, len 5 -> 1,1,0,1,1
      pattern = 16'h001B; len = 5'd5; start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (24) cycle();
      check("single.cnt", {24'd0, cnt4}, 32'd1);

      // three looped frames, loop dropped before the third frame end
      loop = 1'b1; start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (44) cycle();
      loop = 1'b0;
      repeat (30) cycle();
      check("loop.cnt", {24'd0, cnt4}, 32'd4);

      // stop at cycle 9 of a frame
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (9) cycle();
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      check("stopmid.busy", {31'd0, busy4}, 32'd0);
      repeat (5) cycle();

      // stop coincident with frame end while looping
      loop = 1'b1; start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (19) cycle();
      stop = 1'b1;
      cycle();
      stop = 1'b0; loop = 1'b0;
      repeat (10) cycle();

      // invalid lengths, then start while busy with changing inputs
      len = 5'd0; start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      check("len0.busy", {31'd0, busy4}, 32'd0);
      len = 5'd17; start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      check("len17.busy", {31'd0, busy4}, 32'd0);
      len = 5'd5; pattern = 16'h001B; start = 1'b1;
      cycle();
      pattern = 16'hA5A4; len = 5'd3;
      repeat (6) cycle();
      start = 1'b0;
      repeat (20) cycle();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start   = ($urandom_range(0, 7) == 0);
         stop    = ($urandom_range(0, 39) == 0);
         loop    = $urandom_range(0, 1) == 1;
         len     = 5'($urandom_range(0, 17));
         pattern = 16'($urandom);
         cycle();
      end
      start = 1'b0; stop = 1'b0; loop = 1'b0;
      repeat (80) cycle();

      // asynchronous reset in the middle of a bit
      pattern = 16'h001B; len = 5'd5; start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (5) cycle();
      #2 rst = 1'b1;
      m4 = m_reset();
      m1 = m_reset();
      #1 compare_all();
      cycle();
      rst = 1'b0;
      cycle();

      // 256 one-bit looped frames on the DIV=1 instance: counter wraps
      pattern = 16'h0001; len = 5'd1; loop = 1'b1; start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (256) cycle();
      check("wrap.cnt1",  {24'd0, cnt1},  32'd0);
      check("wrap.done1", {31'd0, done1}, 32'd1);
      loop = 1'b0;
      repeat (10) cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
